// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: source indices, default widths and slot layout.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_REG_AW = 5;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_MDU = 1;
  localparam int unsigned SRC_LSU = 2;
  localparam int unsigned NUM_SRC = 3;

  // Bit positions in the pairwise age matrix; a set bit means the first source is older.
  localparam int unsigned AGE_ALU_MDU = 0;
  localparam int unsigned AGE_ALU_LSU = 1;
  localparam int unsigned AGE_MDU_LSU = 2;

  typedef struct packed {
    logic                 full;
    logic [WB_REG_AW-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } slot_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Result handshakes from the three execution units plus the register-file writeback port.
interface writeback_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);

  logic              stall_writeback_i;
  logic              alu_valid_i;
  logic [REG_AW-1:0] alu_rd_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_ready_o;
  logic              mdu_valid_i;
  logic [REG_AW-1:0] mdu_rd_i;
  logic [DATA_W-1:0] mdu_data_i;
  logic              mdu_ready_o;
  logic              lsu_valid_i;
  logic [REG_AW-1:0] lsu_rd_i;
  logic [DATA_W-1:0] lsu_data_i;
  logic              lsu_ready_o;
  logic              reg_write_wb_o;
  logic [REG_AW-1:0] reg_rd_wb_o;
  logic [DATA_W-1:0] reg_rd_data_wb_o;
  logic              stall_writeback_o;

  modport master (
    output stall_writeback_i,
    output alu_valid_i, alu_rd_i, alu_data_i,
    input  alu_ready_o,
    output mdu_valid_i, mdu_rd_i, mdu_data_i,
    input  mdu_ready_o,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  lsu_ready_o,
    input  reg_write_wb_o, reg_rd_wb_o, reg_rd_data_wb_o,
    input  stall_writeback_o
  );

  modport slave (
    input  stall_writeback_i,
    input  alu_valid_i, alu_rd_i, alu_data_i,
    output alu_ready_o,
    input  mdu_valid_i, mdu_rd_i, mdu_data_i,
    output mdu_ready_o,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    output lsu_ready_o,
    output reg_write_wb_o, reg_rd_wb_o, reg_rd_data_wb_o,
    output stall_writeback_o
  );

endinterface

// File: rtl/wb_slot.sv
// Single-entry result holding register; load fills it, clear empties it.
module wb_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              clear,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic [REG_AW-1:0] rd,
  output logic [DATA_W-1:0] data
);

  logic              full_q, full_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Load and clear never coincide: a slot is only loaded while empty and only cleared while full.
  always_comb begin
    full_d = full_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (clear) begin
      full_d = 1'b0;
    end
    if (load) begin
      full_d = 1'b1;
      rd_d   = rd_in;
      data_d = data_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign rd   = rd_q;
  assign data = data_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Buffers one result per execution unit and issues the oldest to the register file each cycle.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic               clk_i,
  input logic               rst_i,
  writeback_arbiter_if.slave bus
);

  logic [NUM_SRC-1:0] src_valid;
  logic [REG_AW-1:0]  src_rd   [NUM_SRC];
  logic [DATA_W-1:0]  src_data [NUM_SRC];
  logic [NUM_SRC-1:0] slot_full;
  logic [REG_AW-1:0]  slot_rd   [NUM_SRC];
  logic [DATA_W-1:0]  slot_data [NUM_SRC];
  logic [NUM_SRC-1:0] slot_load;
  logic [NUM_SRC-1:0] win;

  logic [2:0]         age_q, age_d;
  logic               write_q, write_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]  data_q, data_d;

  assign src_valid[SRC_ALU] = bus.alu_valid_i;
  assign src_valid[SRC_MDU] = bus.mdu_valid_i;
  assign src_valid[SRC_LSU] = bus.lsu_valid_i;
  assign src_rd[SRC_ALU]    = bus.alu_rd_i;
  assign src_rd[SRC_MDU]    = bus.mdu_rd_i;
  assign src_rd[SRC_LSU]    = bus.lsu_rd_i;
  assign src_data[SRC_ALU]  = bus.alu_data_i;
  assign src_data[SRC_MDU]  = bus.mdu_data_i;
  assign src_data[SRC_LSU]  = bus.lsu_data_i;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    // A result for x0 is taken off the source but never stored.
    assign slot_load[g] = src_valid[g] && !slot_full[g] && (src_rd[g] != '0);

    wb_slot #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load    (slot_load[g]),
      .clear   (win[g]),
      .rd_in   (src_rd[g]),
      .data_in (src_data[g]),
      .full    (slot_full[g]),
      .rd      (slot_rd[g]),
      .data    (slot_data[g])
    );
  end

  // Oldest full slot wins; the age matrix stays a total order over full slots.
  always_comb begin
    win = '0;
    if (!bus.stall_writeback_i) begin
      win[SRC_ALU] = slot_full[SRC_ALU]
                   && (!slot_full[SRC_MDU] || age_q[AGE_ALU_MDU])
                   && (!slot_full[SRC_LSU] || age_q[AGE_ALU_LSU]);
      win[SRC_MDU] = slot_full[SRC_MDU]
                   && (!slot_full[SRC_ALU] || !age_q[AGE_ALU_MDU])
                   && (!slot_full[SRC_LSU] || age_q[AGE_MDU_LSU]);
      win[SRC_LSU] = slot_full[SRC_LSU]
                   && (!slot_full[SRC_ALU] || !age_q[AGE_ALU_LSU])
                   && (!slot_full[SRC_MDU] || !age_q[AGE_MDU_LSU]);
    end
  end

  // A fill makes that source younger; simultaneous fills rank lsu, then mdu, then alu.
  always_comb begin
    age_d = age_q;
    if (slot_load[SRC_ALU]) begin
      age_d[AGE_ALU_MDU] = 1'b0;
      age_d[AGE_ALU_LSU] = 1'b0;
    end else begin
      if (slot_load[SRC_MDU]) age_d[AGE_ALU_MDU] = 1'b1;
      if (slot_load[SRC_LSU]) age_d[AGE_ALU_LSU] = 1'b1;
    end
    if (slot_load[SRC_MDU]) begin
      age_d[AGE_MDU_LSU] = 1'b0;
    end else if (slot_load[SRC_LSU]) begin
      age_d[AGE_MDU_LSU] = 1'b1;
    end
  end

  always_comb begin
    write_d = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    unique case (win)
      3'b001: begin
        write_d = 1'b1;
        rd_d    = slot_rd[SRC_ALU];
        data_d  = slot_data[SRC_ALU];
      end
      3'b010: begin
        write_d = 1'b1;
        rd_d    = slot_rd[SRC_MDU];
        data_d  = slot_data[SRC_MDU];
      end
      3'b100: begin
        write_d = 1'b1;
        rd_d    = slot_rd[SRC_LSU];
        data_d  = slot_data[SRC_LSU];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      age_q   <= '0;
      write_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      age_q   <= age_d;
      write_q <= write_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign bus.alu_ready_o       = !slot_full[SRC_ALU];
  assign bus.mdu_ready_o       = !slot_full[SRC_MDU];
  assign bus.lsu_ready_o       = !slot_full[SRC_LSU];
  assign bus.reg_write_wb_o    = write_q;
  assign bus.reg_rd_wb_o       = rd_q;
  assign bus.reg_rd_data_wb_o  = data_q;
  assign bus.stall_writeback_o = |(src_valid & slot_full);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: ordering, discard of x0, stall hold and async reset.
module tb_writeback_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  writeback_arbiter_if #(.DATA_W(32), .REG_AW(5)) bus ();

  writeback_arbiter #(
    .DATA_W (32),
    .REG_AW (5)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_writeback_i = 1'b0;
    bus.alu_valid_i = 1'b0; bus.alu_rd_i = '0; bus.alu_data_i = '0;
    bus.mdu_valid_i = 1'b0; bus.mdu_rd_i = '0; bus.mdu_data_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_data_i = '0;
  endtask

  task automatic check_write(input string name, input logic exp_we, input logic [4:0] exp_rd,
                             input logic [31:0] exp_data, input logic check_payload);
    vectors++;
    if (bus.reg_write_wb_o !== exp_we) begin
      miscompares++;
      $display("FAIL %s we: got %b want %b", name, bus.reg_write_wb_o, exp_we);
    end
    if (check_payload) begin
      vectors++;
      if (bus.reg_rd_wb_o !== exp_rd || bus.reg_rd_data_wb_o !== exp_data) begin
        miscompares++;
        $display("FAIL %s payload: got rd=%0d data=%h want rd=%0d data=%h", name,
                 bus.reg_rd_wb_o, bus.reg_rd_data_wb_o, exp_rd, exp_data);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({bus.alu_ready_o, bus.mdu_ready_o, bus.lsu_ready_o} !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 111",
               {bus.alu_ready_o, bus.mdu_ready_o, bus.lsu_ready_o});
    end
    vectors++;
    if (bus.stall_writeback_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: got %b want 0", bus.stall_writeback_o);
    end
    check_write("reset_out", 1'b0, 5'd0, 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd5; bus.alu_data_i = 32'hDEADBEEF;
    next_cycle();
    bus.alu_valid_i = 1'b0;
    vectors++;
    if (bus.alu_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready_low: got %b want 0", bus.alu_ready_o);
    end
    check_write("single_e1", 1'b0, 5'd0, 32'h0, 1'b0);
    next_cycle();
    check_write("single_e2", 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    vectors++;
    if (bus.alu_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ready_back: got %b want 1", bus.alu_ready_o);
    end
    next_cycle();
    check_write("single_e3", 1'b0, 5'd5, 32'hDEADBEEF, 1'b1);
  endtask

  task automatic test_waw();
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd3; bus.lsu_data_i = 32'hAAAA0001;
    next_cycle();
    bus.lsu_valid_i = 1'b0;
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd3; bus.alu_data_i = 32'hBBBB0002;
    next_cycle();
    bus.alu_valid_i = 1'b0;
    check_write("waw_lsu", 1'b1, 5'd3, 32'hAAAA0001, 1'b1);
    next_cycle();
    check_write("waw_alu", 1'b1, 5'd3, 32'hBBBB0002, 1'b1);
    next_cycle();
    check_write("waw_done", 1'b0, 5'd3, 32'hBBBB0002, 1'b1);
  endtask

  task automatic test_all_three();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd1; bus.alu_data_i = 32'h11111111;
    bus.mdu_valid_i = 1'b1; bus.mdu_rd_i = 5'd2; bus.mdu_data_i = 32'h22222222;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd3; bus.lsu_data_i = 32'h33333333;
    next_cycle();
    idle_inputs();
    next_cycle();
    check_write("all_lsu", 1'b1, 5'd3, 32'h33333333, 1'b1);
    next_cycle();
    check_write("all_mdu", 1'b1, 5'd2, 32'h22222222, 1'b1);
    next_cycle();
    check_write("all_alu", 1'b1, 5'd1, 32'h11111111, 1'b1);
    next_cycle();
    check_write("all_done", 1'b0, 5'd1, 32'h11111111, 1'b1);
  endtask

  task automatic test_rd_zero();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd0; bus.alu_data_i = 32'hCAFEF00D;
    next_cycle();
    bus.alu_valid_i = 1'b0;
    vectors++;
    if (bus.alu_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rd0_ready: got %b want 1", bus.alu_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      check_write("rd0_no_write", 1'b0, 5'd1, 32'h11111111, 1'b1);
      next_cycle();
    end
  endtask

  task automatic test_stall();
    bus.stall_writeback_i = 1'b1;
    bus.mdu_valid_i = 1'b1; bus.mdu_rd_i = 5'd7; bus.mdu_data_i = 32'h77777777;
    next_cycle();
    bus.mdu_rd_i = 5'd8; bus.mdu_data_i = 32'h88888888;
    for (int i = 0; i < 4; i++) begin
      check_write("stall_hold", 1'b0, 5'd0, 32'h0, 1'b0);
      vectors++;
      if (bus.stall_writeback_o !== 1'b1 || bus.mdu_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_out: got stall=%b ready=%b want stall=1 ready=0",
                 bus.stall_writeback_o, bus.mdu_ready_o);
      end
      next_cycle();
    end
    bus.stall_writeback_i = 1'b0;
    next_cycle();
    check_write("stall_release", 1'b1, 5'd7, 32'h77777777, 1'b1);
    vectors++;
    if (bus.mdu_ready_o !== 1'b1 || bus.stall_writeback_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drain: got ready=%b stall=%b want ready=1 stall=0",
               bus.mdu_ready_o, bus.stall_writeback_o);
    end
    next_cycle();
    bus.mdu_valid_i = 1'b0;
    check_write("stall_refill", 1'b0, 5'd7, 32'h77777777, 1'b1);
    vectors++;
    if (bus.mdu_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_refill_ready: got %b want 0", bus.mdu_ready_o);
    end
    next_cycle();
    check_write("stall_pending", 1'b1, 5'd8, 32'h88888888, 1'b1);
    next_cycle();
  endtask

  task automatic test_async_reset();
    bus.stall_writeback_i = 1'b1;
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd9;  bus.alu_data_i = 32'h99999999;
    bus.mdu_valid_i = 1'b1; bus.mdu_rd_i = 5'd10; bus.mdu_data_i = 32'hAAAAAAAA;
    next_cycle();
    bus.alu_valid_i = 1'b0;
    bus.mdu_valid_i = 1'b0;
    vectors++;
    if (bus.alu_ready_o !== 1'b0 || bus.mdu_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_fill: got alu_ready=%b mdu_ready=%b want 0 0",
               bus.alu_ready_o, bus.mdu_ready_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_write("arst_out", 1'b0, 5'd0, 32'h0, 1'b1);
    vectors++;
    if ({bus.alu_ready_o, bus.mdu_ready_o, bus.lsu_ready_o} !== 3'b111) begin
      miscompares++;
      $display("FAIL arst_ready: got %b want 111",
               {bus.alu_ready_o, bus.mdu_ready_o, bus.lsu_ready_o});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.stall_writeback_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_write("arst_no_write", 1'b0, 5'd0, 32'h0, 1'b1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_waw();
    test_all_three();
    test_rd_zero();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage that collects completed results from the ALU, MUL/DIV unit and load/store unit.
- Buffers up to one result per source and issues at most one register-file write per cycle, oldest result first.
- Drives the writeback port of the register file: reg_write_wb, reg_rd_wb and reg_rd_data_wb.
- Each writeback decrements the register file's per-register pending counter, so every accepted result with rd != 0 yields exactly one write pulse.

Parameters:
- DATA_W, 32, result data width.
- REG_AW, 5, register index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_writeback_i  in  1  pipeline-controller hold; no write issued this cycle.
- alu_valid_i  in  1  ALU result valid.
- alu_rd_i  in  REG_AW  ALU destination register.
- alu_data_i  in  DATA_W  ALU result.
- alu_ready_o  out  1  ALU slot can accept.
- mdu_valid_i  in  1  MUL/DIV result valid.
- mdu_rd_i  in  REG_AW  MUL/DIV destination register.
- mdu_data_i  in  DATA_W  MUL/DIV result.
- mdu_ready_o  out  1  MUL/DIV slot can accept.
- lsu_valid_i  in  1  load result valid.
- lsu_rd_i  in  REG_AW  load destination register.
- lsu_data_i  in  DATA_W  load result.
- lsu_ready_o  out  1  load slot can accept.
- reg_write_wb_o  out  1  one-cycle write strobe to the register file.
- reg_rd_wb_o  out  REG_AW  write index.
- reg_rd_data_wb_o  out  DATA_W  write data.
- stall_writeback_o  out  1  to pipeline controller; asserted when some source is valid but its slot is full.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All slots empty; age state cleared.
  - reg_write_wb_o=0, reg_rd_wb_o=0, reg_rd_data_wb_o=0.
  - All ready_o=1; stall_writeback_o=0.
- Slots: one per source, each holding {full, rd, data}.
  - x_ready_o = !slot_x.full. This is combinational from registered state only; there is no valid->ready path.
- Accept: at a clock edge with x_valid_i && x_ready_o:
  - If rd != 0, the slot loads {1, rd, data}.
  - If rd == 0, the result is consumed and discarded; the slot stays empty and no write pulse is generated.
- Age tracking:
  - 3-bit pairwise older matrix (alu<mdu, alu<lsu, mdu<lsu).
  - A newly filled slot becomes younger than every currently full slot.
  - Same-edge fills are ordered lsu older than mdu, mdu older than alu.
- Issue, evaluated each cycle on registered slot state:
  - If stall_writeback_i=0 and any slot is full, the winner is the oldest full slot.
  - At the next edge, the winner's {rd, data} loads the output registers, reg_write_wb_o is set to 1, and the winner slot is cleared.
  - Otherwise reg_write_wb_o is set to 0 at the next edge; rd/data hold their last values.
- reg_write_wb_o is a single-cycle pulse per result and is never held high across a stall, so there is no double decrement.
- Latency: valid at edge N -> slot full after N -> reg_write_wb_o high after N+1 (if uncontended) -> register file writes at edge N+2.
- Drain and refill in the same edge:
  - The winner's ready_o was 0 during that cycle, so it cannot refill on that edge.
  - It is ready in the following cycle; sustained single-source throughput is one result per 2 cycles.
  - Three sources together sustain one write per cycle.
- stall_writeback_o = OR over sources of (x_valid_i && slot_x.full).
- Ordering contract: upstream guarantees no two sources present the same nonzero rd on the same edge. Distinct-edge WAW pairs are written in arrival order by construction.
- stall_writeback_i held for many cycles: slots retain contents, ages are unchanged, no writes are issued.
- Reset asserted mid-operation: buffered results are lost. The pipeline controller resets the register file in the same reset domain.

Decomposition:
- Shared package wb_pkg:
  - SRC_ALU=0, SRC_MDU=1, SRC_LSU=2, NUM_SRC=3.
  - Slot struct/typedef {full, rd[REG_AW], data[DATA_W]}.
- Sub-module wb_slot: single-entry holding register with load/clear. Instantiated 3 times.
- Age matrix and winner select live in the top.

Test Plan:
- Reset then single ALU result rd=5, data=0xDEADBEEF -> exactly one reg_write_wb_o pulse 2 edges later with rd=5, data=0xDEADBEEF; alu_ready_o low for one cycle.
- LSU rd=3 at edge 1, ALU rd=3 at edge 2 -> writes in order: LSU value then ALU value; final value written to x3 is the ALU data.
- All three sources valid on the same edge (rd=1,2,3) -> writes on consecutive cycles in order lsu(3), mdu(2), alu(1); no gaps.
- ALU result rd=0 -> accepted (ready stays 1), no reg_write_wb_o pulse.
- Fill the MDU slot, hold stall_writeback_i=1 for 4 cycles with mdu_valid_i=1 -> no write, stall_writeback_o=1 throughout. Release -> one write; slot accepts the pending result next cycle.
- Pulse rst_i low asynchronously while 2 slots are full -> outputs zero immediately, all ready_o=1, no writes after reset release.
